// File: rtl/db_query_client.sv
// -----------------------------------------------------------------------------
// db_query_client
//   Request-side front end for the key/value DB. Parser requests are accepted,
//   forwarded to the DB as one-cycle strobes, and tracked in an in-order FIFO
//   of {tag, issue_time}. In-order DB responses retire the FIFO head. A head
//   that waits too long is retired as timed out, and its eventual late response
//   is absorbed by a skip counter. Statistics counters wrap.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   req_valid/ready parser handshake; req_key/op/tag request payload
//   db_valid        one-cycle DB request strobe with db_key/db_flag
//   db_rsp_valid    DB response strobe with db_rsp_flag
//   res_valid       one-cycle result strobe with res_tag/res_flag/res_timeout
//   cnt_req         accepted requests
//   cnt_timeout     timed-out requests
//   cnt_orphan      discarded unmatched responses
// -----------------------------------------------------------------------------
module db_query_client #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int TAG_SIZE  = 8,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [KEY_SIZE-1:0]  req_key,
  input  logic [FLAG_SIZE-1:0] req_op,
  input  logic [TAG_SIZE-1:0]  req_tag,
  output logic                 db_valid,
  output logic [KEY_SIZE-1:0]  db_key,
  output logic [FLAG_SIZE-1:0] db_flag,
  input  logic                 db_rsp_valid,
  input  logic [FLAG_SIZE-1:0] db_rsp_flag,
  output logic                 res_valid,
  output logic [TAG_SIZE-1:0]  res_tag,
  output logic [FLAG_SIZE-1:0] res_flag,
  output logic                 res_timeout,
  output logic [31:0]          cnt_req,
  output logic [31:0]          cnt_timeout,
  output logic [31:0]          cnt_orphan
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [15:0]      TIMEOUT_C = 16'(TIMEOUT);

  // Outstanding request storage (no reset needed: validity comes from count_q)
  logic [TAG_SIZE-1:0] tag_mem_q  [DEPTH];
  logic [15:0]         time_mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     skip_q, skip_d;
  logic [15:0]          idle_q, idle_d;
  logic [15:0]          timer_q, timer_d;
  logic                 ready_q, ready_d;
  logic                 db_valid_q, db_valid_d;
  logic [KEY_SIZE-1:0]  db_key_q, db_key_d;
  logic [FLAG_SIZE-1:0] db_flag_q, db_flag_d;
  logic                 res_valid_q, res_valid_d;
  logic [TAG_SIZE-1:0]  res_tag_q, res_tag_d;
  logic [FLAG_SIZE-1:0] res_flag_q, res_flag_d;
  logic                 res_timeout_q, res_timeout_d;
  logic [31:0]          cnt_req_q, cnt_req_d;
  logic [31:0]          cnt_timeout_q, cnt_timeout_d;
  logic [31:0]          cnt_orphan_q, cnt_orphan_d;

  logic        accept_s;
  logic        empty_s;
  logic [15:0] issue_time_s;
  logic [15:0] head_age_s;
  logic        rsp_skip_s;
  logic        rsp_match_s;
  logic        rsp_orphan_s;
  logic        timeout_s;
  logic        pop_s;
  logic        idle_cycle_s;
  logic        idle_clear_s;

  // Retire decision: at most one pop per cycle, responses beat timeouts
  always_comb begin
    accept_s     = req_valid & ready_q;
    empty_s      = (count_q == CNT_ZERO);
    // The entry is stamped with the cycle in which db_valid is high
    issue_time_s = timer_q + 16'd1;
    head_age_s   = timer_q - time_mem_q[rd_ptr_q];
    rsp_skip_s   = db_rsp_valid & (skip_q != CNT_ZERO);
    rsp_match_s  = db_rsp_valid & (skip_q == CNT_ZERO) & ~empty_s;
    rsp_orphan_s = db_rsp_valid & (skip_q == CNT_ZERO) & empty_s;
    // A response absorbed by skip is not usable, so the head may still time out
    timeout_s    = ~(db_rsp_valid & (skip_q == CNT_ZERO)) & ~empty_s &
                   (head_age_s >= TIMEOUT_C);
    pop_s        = rsp_match_s | timeout_s;
    idle_cycle_s = empty_s & ~db_rsp_valid;
    idle_clear_s = idle_cycle_s & (idle_q >= (TIMEOUT_C - 16'd1));
  end

  // FIFO bookkeeping, skip tracking and idle recovery
  always_comb begin
    wr_ptr_d = accept_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    count_d = count_q;
    if (accept_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!accept_s && pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end

    skip_d = skip_q;
    if (rsp_skip_s && !timeout_s) begin
      skip_d = skip_q - CNT_ONE;
    end else if (timeout_s && !rsp_skip_s) begin
      skip_d = (skip_q == DEPTH_C) ? skip_q : (skip_q + CNT_ONE);
    end else if (idle_clear_s) begin
      // Long quiet period with nothing outstanding: late responses are lost
      skip_d = CNT_ZERO;
    end else begin
      skip_d = skip_q;
    end

    idle_d = 16'd0;
    if (idle_cycle_s) begin
      idle_d = idle_clear_s ? idle_q : (idle_q + 16'd1);
    end else begin
      idle_d = 16'd0;
    end

    timer_d = timer_q + 16'd1;
    ready_d = (count_d < DEPTH_C);
  end

  // Registered DB request, result and statistics outputs
  always_comb begin
    db_valid_d = accept_s;
    db_key_d   = accept_s ? req_key : db_key_q;
    db_flag_d  = accept_s ? req_op  : db_flag_q;

    res_valid_d   = pop_s;
    res_timeout_d = timeout_s;
    res_tag_d     = pop_s ? tag_mem_q[rd_ptr_q] : res_tag_q;
    res_flag_d    = res_flag_q;
    if (rsp_match_s) begin
      res_flag_d = db_rsp_flag;
    end else if (timeout_s) begin
      res_flag_d = FLAG_SIZE'(0);
    end else begin
      res_flag_d = res_flag_q;
    end

    cnt_req_d     = accept_s     ? (cnt_req_q + 32'd1)     : cnt_req_q;
    cnt_timeout_d = timeout_s    ? (cnt_timeout_q + 32'd1) : cnt_timeout_q;
    cnt_orphan_d  = rsp_orphan_s ? (cnt_orphan_q + 32'd1)  : cnt_orphan_q;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q      <= PTR_W'(0);
      rd_ptr_q      <= PTR_W'(0);
      count_q       <= CNT_ZERO;
      skip_q        <= CNT_ZERO;
      idle_q        <= 16'd0;
      timer_q       <= 16'd0;
      ready_q       <= 1'b0;
      db_valid_q    <= 1'b0;
      db_key_q      <= KEY_SIZE'(0);
      db_flag_q     <= FLAG_SIZE'(0);
      res_valid_q   <= 1'b0;
      res_tag_q     <= TAG_SIZE'(0);
      res_flag_q    <= FLAG_SIZE'(0);
      res_timeout_q <= 1'b0;
      cnt_req_q     <= 32'd0;
      cnt_timeout_q <= 32'd0;
      cnt_orphan_q  <= 32'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      skip_q        <= skip_d;
      idle_q        <= idle_d;
      timer_q       <= timer_d;
      ready_q       <= ready_d;
      db_valid_q    <= db_valid_d;
      db_key_q      <= db_key_d;
      db_flag_q     <= db_flag_d;
      res_valid_q   <= res_valid_d;
      res_tag_q     <= res_tag_d;
      res_flag_q    <= res_flag_d;
      res_timeout_q <= res_timeout_d;
      cnt_req_q     <= cnt_req_d;
      cnt_timeout_q <= cnt_timeout_d;
      cnt_orphan_q  <= cnt_orphan_d;
    end
  end

  // FIFO payload write on accept
  always_ff @(posedge clk) begin
    if (accept_s) begin
      tag_mem_q[wr_ptr_q]  <= req_tag;
      time_mem_q[wr_ptr_q] <= issue_time_s;
    end
  end

  assign req_ready   = ready_q;
  assign db_valid    = db_valid_q;
  assign db_key      = db_key_q;
  assign db_flag     = db_flag_q;
  assign res_valid   = res_valid_q;
  assign res_tag     = res_tag_q;
  assign res_flag    = res_flag_q;
  assign res_timeout = res_timeout_q;
  assign cnt_req     = cnt_req_q;
  assign cnt_timeout = cnt_timeout_q;
  assign cnt_orphan  = cnt_orphan_q;

endmodule
